serial_adder: RTL and testbench

- Bit-serial adder, LSB-first, built around a single full-adder cell and a carry flip-flop.
- Serves as the addition counterpart to the team's subtractor datapath.
- Loads two WIDTH-bit operands on a start strobe and produces sum/carry after WIDTH cycles, signalled by a one-cycle done pulse.
- Used in area-constrained arithmetic paths where throughput is not critical.

---
 rtl/serial_arith_pkg.sv | 20 ++
 rtl/full_adder_bit.sv | 14 +
 rtl/serial_adder.sv | 191 +++++++++++++++++++
 tb/tb_serial_adder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding,
// default operand width and per-operation cycle cost.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned DefaultWidth = 8;

    // One capture cycle plus WIDTH shift cycles plus the DONE cycle, back to IDLE.
    function automatic int unsigned cycles_per_op(input int unsigned width);
        return width + 2;
    endfunction

    localparam int unsigned DefaultCyclesPerOp = DefaultWidth + 2;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder; the only arithmetic cell of the
// bit-serial datapath.
module full_adder_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell, a carry flop and WIDTH shift cycles.
// Optional signed overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e r_state;
    state_e w_state_nxt;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic [CntW-1:0]  r_cnt;

    logic [WIDTH-1:0] w_a_sr_nxt;
    logic [WIDTH-1:0] w_b_sr_nxt;
    logic [WIDTH-1:0] w_res_sr_nxt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_carry_nxt;
    logic             w_cout_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [CntW-1:0]  w_cnt_nxt;

    logic             w_s;
    logic             w_co;
    logic             w_start_acc;
    logic             w_last;

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;
    logic w_ovf_nxt;
`endif

    full_adder_bit u_fa (
        .i_a  (r_a_sr[0]),
        .i_b  (r_b_sr[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    assign w_start_acc = (r_state == StIdle) && i_start;
    assign w_last      = (r_state == StShift) && (r_cnt == CntLast);

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StShift;
                end
            end
            StShift: begin
                if (r_cnt == CntLast) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // FSM: outputs, decoded from the next state so busy/done come straight off flops
    always_comb begin
        w_busy_nxt = (w_state_nxt == StShift);
        w_done_nxt = (w_state_nxt == StDone);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Datapath next-state: capture on accepted start, one bit per SHIFT cycle
    always_comb begin
        w_a_sr_nxt   = r_a_sr;
        w_b_sr_nxt   = r_b_sr;
        w_res_sr_nxt = r_res_sr;
        w_carry_nxt  = r_carry;
        w_cnt_nxt    = r_cnt;
        w_sum_nxt    = r_sum;
        w_cout_nxt   = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
        w_ovf_nxt    = r_ovf;
`endif
        if (w_start_acc) begin
            w_a_sr_nxt   = i_a;
            w_b_sr_nxt   = i_b;
            w_res_sr_nxt = '0;
            w_carry_nxt  = i_cin;
            w_cnt_nxt    = '0;
        end else if (r_state == StShift) begin
            w_a_sr_nxt   = r_a_sr >> 1;
            w_b_sr_nxt   = r_b_sr >> 1;
            w_res_sr_nxt = {w_s, r_res_sr[WIDTH-1:1]};
            w_carry_nxt  = w_co;
            w_cnt_nxt    = r_cnt + CntW'(1);
            if (w_last) begin
                w_sum_nxt  = {w_s, r_res_sr[WIDTH-1:1]};
                w_cout_nxt = w_co;
`ifdef SERIAL_ADDER_OVF_EN
                // On the MSB cycle r_carry is the carry into the MSB.
                w_ovf_nxt  = r_carry ^ w_co;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_a_sr   <= w_a_sr_nxt;
            r_b_sr   <= w_b_sr_nxt;
            r_res_sr <= w_res_sr_nxt;
            r_carry  <= w_carry_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sum    <= w_sum_nxt;
            r_cout   <= w_cout_nxt;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign o_ovf = r_ovf;
`endif

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); ovf checks are
// compiled in only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(
        .WIDTH (W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .o_ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE and reports what it saw; the caller compares.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         output int cycles, output int busy_cnt, output int changes,
                         output logic [W-1:0] rsum, output logic rcout, output logic rovf,
                         output logic done_after);
        logic [W-1:0] sum0;
        logic         cout0;
        sum0     = sum;
        cout0    = cout;
        cycles   = 0;
        busy_cnt = 0;
        changes  = 0;
        rovf     = 1'b0;
        a        = oa;
        b        = ob;
        cin      = oc;
        start    = 1'b1;
        tick();
        start = 1'b0;
        a     = ~oa;
        b     = ~ob;
        cin   = ~oc;
        if (busy === 1'b1) busy_cnt++;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            if (sum !== sum0 || cout !== cout0) changes++;
        end
        rsum  = sum;
        rcout = cout;
`ifdef SERIAL_ADDER_OVF_EN
        rovf = ovf;
`endif
        tick();
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++;
        if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done);
        end
    endtask

    task automatic test_basic();
        int cy, bc, ch;
        logic [W-1:0] s;
        logic co, ov, da;
        do_op(8'h3C, 8'h05, 1'b0, cy, bc, ch, s, co, ov, da);
        checks++;
        if (cy != 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", cy); end
        checks++;
        if (bc != 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
        checks++;
        if (s !== 8'h41 || co !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got=%b_%h exp=0_41", co, s);
        end
        checks++;
        if (ch != 0) begin failures++; $display("FAIL basic_hold changes=%0d exp=0", ch); end
        checks++;
        if (da !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", da); end
    endtask

    task automatic test_carry();
        int cy, bc, ch;
        logic [W-1:0] s;
        logic co, ov, da;
        do_op(8'hFF, 8'h01, 1'b0, cy, bc, ch, s, co, ov, da);
        checks++;
        if (s !== 8'h00 || co !== 1'b1) begin
            failures++;
            $display("FAIL carry_ff01 got=%b_%h exp=1_00", co, s);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ov !== 1'b0) begin failures++; $display("FAIL ovf_ff01 got=%b exp=0", ov); end
`endif
        do_op(8'hFF, 8'hFF, 1'b1, cy, bc, ch, s, co, ov, da);
        checks++;
        if (s !== 8'hFF || co !== 1'b1) begin
            failures++;
            $display("FAIL carry_ffff1 got=%b_%h exp=1_ff", co, s);
        end
        checks++;
        if (ch != 0) begin failures++; $display("FAIL carry_hold changes=%0d exp=0", ch); end
        do_op(8'h7F, 8'h01, 1'b0, cy, bc, ch, s, co, ov, da);
        checks++;
        if (s !== 8'h80 || co !== 1'b0) begin
            failures++;
            $display("FAIL carry_7f01 got=%b_%h exp=0_80", co, s);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ov !== 1'b1) begin failures++; $display("FAIL ovf_7f01 got=%b exp=1", ov); end
`endif
    endtask

    // start held high across SHIFT and DONE: only re-accepted once back in IDLE
    task automatic test_ignore();
        int n_done;
        int first_done;
        int second_done;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        n_done      = 0;
        first_done  = 0;
        second_done = 0;
        s1          = '0;
        s2          = '0;
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        a = 8'h01;
        b = 8'h01;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i == 10) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin first_done = i; s1 = sum; end
                if (n_done == 2) begin second_done = i; s2 = sum; end
            end
        end
        checks++;
        if (n_done != 2) begin failures++; $display("FAIL ignore_done_count got=%0d exp=2", n_done); end
        checks++;
        if (first_done != 8 || s1 !== 8'h30) begin
            failures++;
            $display("FAIL ignore_first got=@%0d/%h exp=@8/30", first_done, s1);
        end
        checks++;
        if (second_done != 18 || s2 !== 8'h02) begin
            failures++;
            $display("FAIL ignore_second got=@%0d/%h exp=@18/02", second_done, s2);
        end
    endtask

    task automatic test_reset_mid();
        int cy, bc, ch;
        logic [W-1:0] s;
        logic co, ov, da;
        logic seen_done;
        do_op(8'h12, 8'h34, 1'b0, cy, bc, ch, s, co, ov, da);
        checks++;
        if (s !== 8'h46 || co !== 1'b0) begin
            failures++;
            $display("FAIL pre_abort got=%b_%h exp=0_46", co, s);
        end
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs got=busy%b done%b %b_%h exp=0 0 0_00",
                     busy, done, cout, sum);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=1 exp=0"); end
        do_op(8'h01, 8'h02, 1'b0, cy, bc, ch, s, co, ov, da);
        checks++;
        if (cy != 8 || s !== 8'h03 || co !== 1'b0) begin
            failures++;
            $display("FAIL post_abort got=@%0d %b_%h exp=@8 0_03", cy, co, s);
        end
    endtask

    task automatic test_random();
        int cy, bc, ch;
        logic [W-1:0] s;
        logic co, ov, da;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        logic [W:0] exp_full;
        int gap;
        int bad_res, bad_lat, bad_spur;
        bad_res  = 0;
        bad_lat  = 0;
        bad_spur = 0;
        for (int n = 0; n < 1000; n++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tick();
                if (done !== 1'b0) bad_spur++;
            end
            do_op(ra, rb, rc, cy, bc, ch, s, co, ov, da);
            exp_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            checks++;
            if ({co, s} !== exp_full) begin
                failures++;
                bad_res++;
                if (bad_res <= 5)
                    $display("FAIL rand_result %h+%h+%b got=%b_%h exp=%b_%h",
                             ra, rb, rc, co, s, exp_full[W], exp_full[W-1:0]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            checks++;
            if (ov !== ((ra[W-1] == rb[W-1]) && (exp_full[W-1] != ra[W-1]))) begin
                failures++;
                $display("FAIL rand_ovf %h+%h+%b got=%b", ra, rb, rc, ov);
            end
`endif
            checks++;
            if (cy != 8 || da !== 1'b0 || ch != 0) begin
                failures++;
                bad_lat++;
                if (bad_lat <= 5)
                    $display("FAIL rand_timing got=@%0d after=%b changes=%0d exp=@8 0 0",
                             cy, da, ch);
            end
        end
        checks++;
        if (bad_spur != 0) begin
            failures++;
            $display("FAIL rand_spurious_done got=%0d exp=0", bad_spur);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
